// File: rtl/arith_exec_pipeline.sv
// ALU execution unit: one op per cycle through a shared combinational ALU, then STAGES elastic
// register stages with valid/ready backpressure, bubble collapsing and ROB flush.
module arith_exec_pipeline #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned ROB_W  = 5,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   opcode,
  input  logic [ROB_W-1:0]  rob_entry,
  input  logic [REG_W-1:0]  dest_reg,
  input  logic [REG_W-1:0]  flag_reg,
  input  logic [DATA_W-1:0] op_a_val,
  input  logic [DATA_W-1:0] op_b_val,
  input  logic [DATA_W-1:0] flags_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROB_W-1:0]  rob_entry_out,
  output logic [REG_W-1:0]  dest_reg_out,
  output logic [REG_W-1:0]  flag_reg_out,
  output logic [DATA_W-1:0] result_val,
  output logic [DATA_W-1:0] result_flags,
  output logic              busy
);

  localparam int unsigned Msb   = DATA_W - 1;
  localparam int unsigned WideW = DATA_W + 1;

  localparam logic [OP_W-1:0] OpAdd = OP_W'(0);
  localparam logic [OP_W-1:0] OpAdc = OP_W'(1);
  localparam logic [OP_W-1:0] OpSub = OP_W'(2);
  localparam logic [OP_W-1:0] OpAnd = OP_W'(3);
  localparam logic [OP_W-1:0] OpOr  = OP_W'(4);
  localparam logic [OP_W-1:0] OpXor = OP_W'(5);
  localparam logic [OP_W-1:0] OpShl = OP_W'(6);
  localparam logic [OP_W-1:0] OpShr = OP_W'(7);

  typedef struct packed {
    logic [ROB_W-1:0]  rob;
    logic [REG_W-1:0]  dest;
    logic [REG_W-1:0]  flag;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] f;
  } payload_t;

  logic [WideW-1:0]  wide;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] alu_f;
  logic              alu_c;
  logic              alu_v;

  // Flag layout: [0] carry/borrow, [1] zero, [2] negative, [3] overflow; upper bits pass through.
  always_comb begin
    wide  = '0;
    alu_q = op_b_val;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (opcode)
      OpAdd, OpAdc: begin
        wide  = {1'b0, op_a_val} + {1'b0, op_b_val} +
                ((opcode == OpAdc) ? WideW'(flags_val[0]) : '0);
        alu_q = wide[Msb:0];
        alu_c = wide[DATA_W];
        alu_v = (op_a_val[Msb] == op_b_val[Msb]) && (alu_q[Msb] != op_a_val[Msb]);
      end
      OpSub: begin
        wide  = {1'b0, op_a_val} - {1'b0, op_b_val};
        alu_q = wide[Msb:0];
        alu_c = wide[DATA_W];
        alu_v = (op_a_val[Msb] != op_b_val[Msb]) && (alu_q[Msb] != op_a_val[Msb]);
      end
      OpAnd: alu_q = op_a_val & op_b_val;
      OpOr:  alu_q = op_a_val | op_b_val;
      OpXor: alu_q = op_a_val ^ op_b_val;
      OpShl: begin
        alu_q = {op_a_val[Msb-1:0], 1'b0};
        alu_c = op_a_val[Msb];
      end
      OpShr: begin
        alu_q = {1'b0, op_a_val[Msb:1]};
        alu_c = op_a_val[0];
      end
      default: alu_q = op_b_val;
    endcase
    alu_f = {flags_val[Msb:4], alu_v, alu_q[Msb], alu_q == '0, alu_c};
  end

  payload_t              new_pl;
  payload_t              pl_q     [STAGES];
  payload_t              stage_in [STAGES];
  logic [STAGES-1:0]     valid_q;
  logic [STAGES-1:0]     up_valid;
  logic [STAGES-1:0]     ready;

  always_comb begin
    new_pl.rob  = rob_entry;
    new_pl.dest = dest_reg;
    new_pl.flag = flag_reg;
    new_pl.q    = alu_q;
    new_pl.f    = alu_f;
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_link
    if (g == 0) begin : g_head
      assign up_valid[g] = in_valid;
      assign stage_in[g] = new_pl;
    end else begin : g_body
      assign up_valid[g] = valid_q[g-1];
      assign stage_in[g] = pl_q[g-1];
    end
  end

  // A stage can accept when any stage from it to the output is empty, or the output drains.
  always_comb begin
    ready = '0;
    for (int i = 0; i < STAGES; i++) begin
      ready[i] = out_ready;
      for (int j = i; j < STAGES; j++) begin
        if (!valid_q[j]) ready[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) pl_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (ready[i]) begin
          valid_q[i] <= up_valid[i];
          if (up_valid[i]) pl_q[i] <= stage_in[i];
        end
      end
    end
  end

  assign in_ready      = ready[0];
  assign out_valid     = valid_q[STAGES-1];
  assign busy          = |valid_q;
  assign rob_entry_out = pl_q[STAGES-1].rob;
  assign dest_reg_out  = pl_q[STAGES-1].dest;
  assign flag_reg_out  = pl_q[STAGES-1].flag;
  assign result_val    = pl_q[STAGES-1].q;
  assign result_flags  = pl_q[STAGES-1].f;

endmodule

// File: tb/tb_arith_exec_pipeline.sv
// Bench for arith_exec_pipeline: directed checks on a STAGES=2 unit, then a random stream into
// STAGES=1 and STAGES=4 (DATA_W=16) units scored against a queue-based reference model.
module tb_arith_exec_pipeline;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic rst;

  logic       d_flush, d_in_valid, d_out_ready, d_in_ready, d_out_valid, d_busy;
  logic [3:0] d_opcode;
  logic [4:0] d_rob, d_dest, d_flagr, d_rob_o, d_dest_o, d_flag_o;
  logic [7:0] d_a, d_b, d_f, d_res, d_rflags;

  logic        r_in_valid;
  logic [3:0]  r_opcode;
  logic [4:0]  r_rob, r_dest, r_flagr;
  logic [15:0] r_a, r_b, r_f;
  logic        r_out_ready [2];
  logic        r_in_ready  [2];
  logic        r_out_valid [2];
  logic        r_busy      [2];
  logic [4:0]  r_rob_o     [2];
  logic [4:0]  r_dest_o    [2];
  logic [4:0]  r_flag_o    [2];
  logic [15:0] r_res       [2];
  logic [15:0] r_rflags    [2];

  typedef struct packed {
    logic [4:0]  rob;
    logic [4:0]  dest;
    logic [4:0]  flag;
    logic [15:0] res;
    logic [15:0] flg;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  arith_exec_pipeline u_dut (
    .clk(clk), .rst(rst), .flush(d_flush), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .opcode(d_opcode), .rob_entry(d_rob), .dest_reg(d_dest), .flag_reg(d_flagr),
    .op_a_val(d_a), .op_b_val(d_b), .flags_val(d_f), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .rob_entry_out(d_rob_o), .dest_reg_out(d_dest_o),
    .flag_reg_out(d_flag_o), .result_val(d_res), .result_flags(d_rflags), .busy(d_busy)
  );

  arith_exec_pipeline #(.DATA_W(16), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(r_in_valid), .in_ready(r_in_ready[0]),
    .opcode(r_opcode), .rob_entry(r_rob), .dest_reg(r_dest), .flag_reg(r_flagr),
    .op_a_val(r_a), .op_b_val(r_b), .flags_val(r_f), .out_valid(r_out_valid[0]),
    .out_ready(r_out_ready[0]), .rob_entry_out(r_rob_o[0]), .dest_reg_out(r_dest_o[0]),
    .flag_reg_out(r_flag_o[0]), .result_val(r_res[0]), .result_flags(r_rflags[0]),
    .busy(r_busy[0])
  );

  arith_exec_pipeline #(.DATA_W(16), .STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(r_in_valid), .in_ready(r_in_ready[1]),
    .opcode(r_opcode), .rob_entry(r_rob), .dest_reg(r_dest), .flag_reg(r_flagr),
    .op_a_val(r_a), .op_b_val(r_b), .flags_val(r_f), .out_valid(r_out_valid[1]),
    .out_ready(r_out_ready[1]), .rob_entry_out(r_rob_o[1]), .dest_reg_out(r_dest_o[1]),
    .flag_reg_out(r_flag_o[1]), .result_val(r_res[1]), .result_flags(r_rflags[1]),
    .busy(r_busy[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU in signed/unsigned integer arithmetic; flags {V,N,Z,C} in bits 3..0.
  function automatic void alu_model(input int w, input int op, input int a, input int b,
                                    input int fin, output int r, output int f);
    int mask, half, sa, sb, s, ss, c, v, cin;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    sa = (a >= half) ? a - (1 << w) : a;
    sb = (b >= half) ? b - (1 << w) : b;
    c = 0;
    v = 0;
    r = b;
    case (op)
      0, 1: begin
        cin = (op == 1) ? (fin & 1) : 0;
        s = a + b + cin;
        r = s & mask;
        c = (s > mask) ? 1 : 0;
        ss = sa + sb + cin;
        v = (ss >= half || ss < -half) ? 1 : 0;
      end
      2: begin
        s = a - b;
        r = s & mask;
        c = (a < b) ? 1 : 0;
        ss = sa - sb;
        v = (ss >= half || ss < -half) ? 1 : 0;
      end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: begin
        r = (a * 2) & mask;
        c = (a >= half) ? 1 : 0;
      end
      7: begin
        r = a / 2;
        c = a % 2;
      end
      default: r = b;
    endcase
    f = (fin & ~15 & mask) | (v << 3) | (((r >= half) ? 1 : 0) << 2) |
        (((r == 0) ? 1 : 0) << 1) | c;
  endfunction

  task automatic step_inst(input int k);
    exp_t e, act;
    int   sz, s, r, f;
    string nm;
    s  = (k == 0) ? 1 : 4;
    nm = $sformatf("s%0d", s);
    sz = (k == 0) ? sb0.size() : sb1.size();
    check({nm, "_in_ready"}, 64'(r_in_ready[k]), 64'((sz < s) || r_out_ready[k]));
    check({nm, "_busy"}, 64'(r_busy[k]), 64'(sz > 0));
    if (r_out_valid[k] && r_out_ready[k]) begin
      check({nm, "_unexpected_out"}, 64'(sz > 0), 64'd1);
      if (sz > 0) begin
        e   = (k == 0) ? sb0.pop_front() : sb1.pop_front();
        act = {r_rob_o[k], r_dest_o[k], r_flag_o[k], r_res[k], r_rflags[k]};
        check({nm, "_payload"}, 64'(act), 64'(e));
      end
    end
    if (r_in_valid && r_in_ready[k]) begin
      alu_model(16, int'(r_opcode), int'(r_a), int'(r_b), int'(r_f), r, f);
      e.rob  = r_rob;
      e.dest = r_dest;
      e.flag = r_flagr;
      e.res  = 16'(r);
      e.flg  = 16'(f);
      if (k == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc;
    rst = 1'b1;
    d_flush = 1'b0; d_in_valid = 1'b0; d_out_ready = 1'b1; d_opcode = '0;
    d_rob = '0; d_dest = '0; d_flagr = '0; d_a = '0; d_b = '0; d_f = '0;
    r_in_valid = 1'b0; r_opcode = '0; r_rob = '0; r_dest = '0; r_flagr = '0;
    r_a = '0; r_b = '0; r_f = '0; r_out_ready[0] = 1'b1; r_out_ready[1] = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 64'(d_out_valid), 64'd0);
    check("rst_busy", 64'(d_busy), 64'd0);
    check("rst_in_ready", 64'(d_in_ready), 64'd1);
    check("rst_result", 64'(d_res), 64'd0);
    check("rst_rob", 64'(d_rob_o), 64'd0);
    rst = 1'b0;

    // Single ADD, two-stage latency
    d_in_valid = 1'b1; d_opcode = 4'd0; d_a = 8'h05; d_b = 8'h03; d_rob = 5'd7;
    d_dest = 5'd3; d_flagr = 5'd4; d_f = 8'h00;
    tick();
    d_in_valid = 1'b0;
    check("add_not_yet", 64'(d_out_valid), 64'd0);
    tick();
    check("add_valid", 64'(d_out_valid), 64'd1);
    check("add_result", 64'(d_res), 64'h08);
    check("add_rob", 64'(d_rob_o), 64'd7);
    check("add_dest", 64'(d_dest_o), 64'd3);
    check("add_flagreg", 64'(d_flag_o), 64'd4);
    check("add_flags", 64'(d_rflags), 64'h00);
    tick();
    check("add_gone", 64'(d_out_valid), 64'd0);
    check("add_idle", 64'(d_busy), 64'd0);

    // Four back-to-back ops
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        d_in_valid = 1'b1; d_rob = 5'(c + 1); d_a = 8'(c); d_b = 8'd1; d_opcode = 4'd0;
      end else begin
        d_in_valid = 1'b0;
      end
      check("b2b_in_ready", 64'(d_in_ready), 64'd1);
      tick();
      check("b2b_out_valid", 64'(d_out_valid), 64'(c >= 1 && c <= 4));
      if (c >= 1 && c <= 4) begin
        check("b2b_rob", 64'(d_rob_o), 64'(c));
        check("b2b_result", 64'(d_res), 64'(c));
      end
    end

    // Stall: output blocked, continuous issue
    d_out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      d_in_valid = 1'b1; d_rob = 5'(10 + acc); d_a = 8'(acc); d_b = 8'h40;
      check("stall_in_ready", 64'(d_in_ready), 64'(k < 2));
      if (d_in_ready) acc++;
      tick();
    end
    d_in_valid = 1'b0;
    check("stall_valid", 64'(d_out_valid), 64'd1);
    check("stall_rob", 64'(d_rob_o), 64'd10);
    check("stall_result", 64'(d_res), 64'h40);
    tick();
    check("stall_hold_rob", 64'(d_rob_o), 64'd10);
    check("stall_hold_valid", 64'(d_out_valid), 64'd1);
    d_out_ready = 1'b1;
    tick();
    check("drain_rob1", 64'(d_rob_o), 64'd11);
    check("drain_valid1", 64'(d_out_valid), 64'd1);
    check("drain_result1", 64'(d_res), 64'h41);
    tick();
    check("drain_empty", 64'(d_out_valid), 64'd0);

    // Flush with two ops in flight and a new op offered
    d_out_ready = 1'b0;
    d_in_valid = 1'b1; d_rob = 5'd20;
    tick();
    d_rob = 5'd21;
    tick();
    check("preflush_valid", 64'(d_out_valid), 64'd1);
    d_flush = 1'b1; d_rob = 5'd22;
    tick();
    d_flush = 1'b0; d_in_valid = 1'b0;
    check("flush_out_valid", 64'(d_out_valid), 64'd0);
    check("flush_busy", 64'(d_busy), 64'd0);
    check("flush_in_ready", 64'(d_in_ready), 64'd1);
    d_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("flush_no_emit", 64'(d_out_valid), 64'd0);
    end

    // Reset with two ops in flight
    d_out_ready = 1'b0;
    d_in_valid = 1'b1; d_rob = 5'd30; d_a = 8'h10; d_b = 8'h20;
    tick();
    d_rob = 5'd31;
    tick();
    d_in_valid = 1'b0;
    check("prerst_busy", 64'(d_busy), 64'd1);
    rst = 1'b1;
    tick();
    check("midrst_out_valid", 64'(d_out_valid), 64'd0);
    check("midrst_result", 64'(d_res), 64'd0);
    check("midrst_in_ready", 64'(d_in_ready), 64'd1);
    check("midrst_busy", 64'(d_busy), 64'd0);
    rst = 1'b0;

    // Random stream against the reference model
    for (int cyc = 0; cyc < 600; cyc++) begin
      r_in_valid = ($urandom_range(0, 9) < 7);
      r_opcode   = 4'($urandom_range(0, 15));
      r_a        = 16'($urandom);
      r_b        = 16'($urandom);
      r_f        = 16'($urandom);
      r_rob      = 5'($urandom);
      r_dest     = 5'($urandom);
      r_flagr    = 5'($urandom);
      r_out_ready[0] = ($urandom_range(0, 9) < 6);
      r_out_ready[1] = ($urandom_range(0, 9) < 6);
      #1;
      step_inst(0);
      step_inst(1);
      tick();
    end
    r_in_valid = 1'b0;
    r_out_ready[0] = 1'b1;
    r_out_ready[1] = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      step_inst(0);
      step_inst(1);
      tick();
    end
    check("s1_drained", 64'(sb0.size()), 64'd0);
    check("s4_drained", 64'(sb1.size()), 64'd0);
    check("s1_final_busy", 64'(r_busy[0]), 64'd0);
    check("s4_final_busy", 64'(r_busy[1]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
